// File: rtl/button_mode_sequencer_if.sv
// Button-path bundle between the board pushbuttons, the mode sequencer and the signal router.
// The sequencer uses the slave view; the board/router side uses the master view.
interface button_mode_sequencer_if;
  logic       btn_mode_raw;
  logic       btn_start_raw;
  logic       btn_reset_raw;
  logic [2:1] btn_raw;
  logic       start;
  logic       reset_btn;
  logic [2:1] button;
  logic [3:0] state;
  logic       mode_long;

  modport master (
    output btn_mode_raw, btn_start_raw, btn_reset_raw, btn_raw,
    input  start, reset_btn, button, state, mode_long
  );

  modport slave (
    input  btn_mode_raw, btn_start_raw, btn_reset_raw, btn_raw,
    output start, reset_btn, button, state, mode_long
  );
endinterface

// File: rtl/button_mode_sequencer.sv
// Synchronises and debounces the raw buttons, turns presses into 1-cycle pulses and
// runs the one-hot mode FSM (with long-press return to CLOCK) for the signal router.
module button_mode_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 200000000,
  parameter int CNT_W           = 28
) (
  input  logic                  clk,
  input  logic                  reset,
  button_mode_sequencer_if.slave bus
);
  localparam int NB      = 5;
  localparam int I_MODE  = 0;
  localparam int I_START = 1;
  localparam int I_RST   = 2;
  localparam int I_B1    = 3;
  localparam int I_B2    = 4;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);

  typedef enum logic [3:0] {
    CLOCK     = 4'b0000,
    COUNTUP   = 4'b1000,
    COUNTDOWN = 4'b0100,
    ALARM     = 4'b0010,
    SETUP     = 4'b0001
  } mode_t;

  logic [NB-1:0]    w_raw;
  logic [NB-1:0]    r_s1;
  logic [NB-1:0]    r_s2;
  logic [NB-1:0]    r_deb;
  logic [NB-1:0]    r_deb_d;
  logic [NB-1:0]    r_pulse;
  logic [CNT_W-1:0] r_cnt [NB];
  logic [CNT_W-1:0] r_hold;
  logic             r_mode_long;
  mode_t            r_state;
  mode_t            w_state_next;

  assign w_raw = {bus.btn_raw[2], bus.btn_raw[1], bus.btn_reset_raw,
                  bus.btn_start_raw, bus.btn_mode_raw};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      r_pulse <= '0;
      // NOTE: this small counter array lives in flops and must restart cleanly, so it is reset
      // element by element (unlike a RAM block, which would be left uninitialised).
      for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
    end else begin
      r_s1    <= w_raw;
      r_s2    <= r_s1;
      r_deb_d <= r_deb;
      r_pulse <= r_deb & ~r_deb_d;
      for (int i = 0; i < NB; i++) begin
        if (r_s2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DEB_LAST) begin
          r_deb[i] <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Hold counter saturates so a long press fires once and never wraps into a second one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold      <= '0;
      r_mode_long <= 1'b0;
    end else begin
      if (!r_deb[I_MODE]) begin
        r_hold <= '0;
      end else if (r_hold != LONG_MAX) begin
        r_hold <= r_hold + 1'b1;
      end
      r_mode_long <= r_deb[I_MODE] && (r_hold == LONG_MAX - 1'b1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= CLOCK;
    else       r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns the next state and no latch is inferred.
    w_state_next = r_state;
    if (r_mode_long) begin
      w_state_next = CLOCK;
    end else begin
      case (r_state)
        CLOCK:     if (r_pulse[I_MODE]) w_state_next = COUNTUP;
        COUNTUP:   if (r_pulse[I_MODE]) w_state_next = COUNTDOWN;
        COUNTDOWN: if (r_pulse[I_MODE]) w_state_next = ALARM;
        ALARM:     if (r_pulse[I_MODE]) w_state_next = SETUP;
        SETUP:     if (r_pulse[I_MODE]) w_state_next = CLOCK;
        default:   w_state_next = CLOCK;
      endcase
    end
  end

  assign bus.start     = r_pulse[I_START];
  assign bus.reset_btn = r_pulse[I_RST];
  assign bus.button    = {r_pulse[I_B2], r_pulse[I_B1]};
  assign bus.state     = r_state;
  assign bus.mode_long = r_mode_long;
endmodule

// File: tb/tb_button_mode_sequencer.sv
// Self-checking bench for button_mode_sequencer: directed scenarios plus random button
// activity, compared every cycle against a behavioural press/mode model.
`timescale 1ns/1ps
module tb_button_mode_sequencer;
  localparam int D    = 4;
  localparam int L    = 20;
  localparam int MAXC = 8192;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] raw_v = '0;   // 0 mode, 1 start, 2 user reset, 3 btn1, 4 btn2

  button_mode_sequencer_if bus ();

  assign bus.btn_mode_raw  = raw_v[0];
  assign bus.btn_start_raw = raw_v[1];
  assign bus.btn_reset_raw = raw_v[2];
  assign bus.btn_raw       = raw_v[4:3];

  button_mode_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .CNT_W          (28)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: a press is accepted once the sampled level has differed from the
  // accepted level for D consecutive samples; its pulse appears 3 cycles after the D-th sample.
  int cyc = 0;
  bit exp_pulse [5][MAXC];
  bit exp_long  [MAXC];
  bit lvl       [5];
  int run       [5];
  int long_slot = -1;
  int m_state   = 0;

  function automatic logic [3:0] code(int idx);
    case (idx)
      1:       return 4'b1000;
      2:       return 4'b0100;
      3:       return 4'b0010;
      4:       return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 5; i++) begin
      lvl[i] = 1'b0;
      run[i] = 0;
      for (int c = 0; c < MAXC; c++) exp_pulse[i][c] = 1'b0;
    end
    for (int c = 0; c < MAXC; c++) exp_long[c] = 1'b0;
    long_slot = -1;
    m_state   = 0;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_clear();
    end else begin
      cyc++;
      if (exp_long[cyc-1])           m_state = 0;
      else if (exp_pulse[0][cyc-1])  m_state = (m_state + 1) % 5;
      for (int i = 0; i < 5; i++) begin
        if (raw_v[i] != lvl[i]) run[i]++;
        else                    run[i] = 0;
        if (run[i] == D) begin
          lvl[i] = raw_v[i];
          run[i] = 0;
          if (lvl[i]) begin
            if (cyc + 3 < MAXC) exp_pulse[i][cyc+3] = 1'b1;
            if (i == 0 && cyc + 2 + L < MAXC) begin
              long_slot = cyc + 2 + L;
              exp_long[long_slot] = 1'b1;
            end
          end else if (i == 0) begin
            if (long_slot >= 0 && cyc + 3 <= long_slot) exp_long[long_slot] = 1'b0;
            long_slot = -1;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {bus.state, bus.mode_long, bus.button, bus.reset_btn, bus.start};
  endfunction

  task automatic step(input string tag);
    logic [8:0] exp;
    int c;
    @(posedge clk);
    @(negedge clk);
    c   = (cyc < MAXC) ? cyc : MAXC - 1;
    exp = {code(m_state), exp_long[c], exp_pulse[4][c], exp_pulse[3][c],
           exp_pulse[2][c], exp_pulse[1][c]};
    check(tag, 32'(outs()), 32'(exp));
  endtask

  task automatic steps(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  task automatic wait_pulse(input string tag, input int which, input int budget, output int at);
    logic hit;
    at = -1;
    for (int n = 0; n < budget && at < 0; n++) begin
      step(tag);
      case (which)
        0:       hit = bus.start;
        1:       hit = bus.button[1];
        2:       hit = bus.button[2];
        default: hit = bus.mode_long;
      endcase
      if (hit) at = cyc;
    end
  endtask

  task automatic press(input string tag, input int idx, input int hold, input int gap);
    raw_v[idx] = 1'b1;
    steps(tag, hold);
    raw_v[idx] = 1'b0;
    steps(tag, gap);
  endtask

  // Asserts reset in the middle of the low clock phase and checks outputs clear at once.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1 check(tag, 32'(outs()), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, at, nlong;
    logic [3:0] seq [5];
    seq = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000};

    reset = 1'b1;
    #3 check("reset_outs", 32'(outs()), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hold", 32'(outs()), 32'h0);
    reset = 1'b0;
    steps("idle", 8);

    // Clean start press: pulse in the cycle after E0+D+2, nothing more while held or on release.
    raw_v[1] = 1'b1;
    e0 = cyc + 1;
    wait_pulse("start_press", 0, 20, at);
    check("start_latency", 32'(at), 32'(e0 + D + 2));
    steps("start_held", 15);
    raw_v[1] = 1'b0;
    steps("start_rel", 12);

    // Bouncing button 1: 1,0,1,0 then steady high.
    raw_v[3] = 1'b1; step("bounce");
    raw_v[3] = 1'b0; step("bounce");
    raw_v[3] = 1'b1; step("bounce");
    raw_v[3] = 1'b0; step("bounce");
    raw_v[3] = 1'b1;
    e0 = cyc + 1;
    wait_pulse("bounce_press", 1, 20, at);
    check("bounce_latency", 32'(at), 32'(e0 + D + 2));
    steps("bounce_held", 10);
    raw_v[3] = 1'b0;
    steps("bounce_rel", 12);

    // Five mode presses walk the full cycle back to CLOCK.
    for (int k = 0; k < 5; k++) begin
      press("mode_cycle", 0, 12, 12);
      check("mode_seq", 32'(bus.state), 32'(seq[k]));
    end

    // Long press from COUNTUP: advance first, then one mode_long and back to CLOCK.
    press("to_countup", 0, 12, 12);
    check("countup", 32'(bus.state), 32'h8);
    raw_v[0] = 1'b1;
    e0 = cyc + 1;
    nlong = 0;
    at = -1;
    for (int n = 0; n < D + L + 45; n++) begin
      step("long_hold");
      if (cyc == e0 + D + 3) check("long_adv_state", 32'(bus.state), 32'h4);
      if (bus.mode_long) begin
        nlong++;
        if (at < 0) at = cyc;
      end
    end
    check("long_at", 32'(at), 32'(e0 + D + 1 + L));
    check("long_once", 32'(nlong), 32'd1);
    check("long_state", 32'(bus.state), 32'h0);
    raw_v[0] = 1'b0;
    steps("long_rel", 12);

    // Coincident start and mode pulses in COUNTDOWN.
    press("to_cd", 0, 12, 12);
    press("to_cd", 0, 12, 12);
    check("countdown", 32'(bus.state), 32'h4);
    raw_v[0] = 1'b1;
    raw_v[1] = 1'b1;
    wait_pulse("coinc", 0, 20, at);
    check("coinc_old_state", 32'(bus.state), 32'h4);
    step("coinc_next");
    check("coinc_new_state", 32'(bus.state), 32'h2);
    steps("coinc_held", 8);
    raw_v[0] = 1'b0;
    raw_v[1] = 1'b0;
    steps("coinc_rel", 12);

    // Reset mid-press: a held button requalifies after release.
    raw_v[4] = 1'b1;
    steps("pre_reset", 3);
    async_reset("reset_mid");
    e0 = cyc + 1;
    wait_pulse("requal", 2, 20, at);
    check("requal_latency", 32'(at), 32'(e0 + D + 2));
    check("requal_state", 32'(bus.state), 32'h0);
    steps("requal_held", 8);
    raw_v[4] = 1'b0;
    steps("requal_rel", 12);

    // Random activity: short glitches, real presses, coincidences and occasional resets.
    for (int n = 0; n < 1500; n++) begin
      step("random");
      for (int i = 0; i < 5; i++)
        if ($urandom_range(0, 9) == 0) raw_v[i] = ~raw_v[i];
      if ($urandom_range(0, 399) == 0) async_reset("random_reset");
    end
    raw_v = '0;
    steps("drain", 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
